// File: rtl/adder_pkg.sv
// Shared definitions for the digit-serial adder: FSM encoding and the
// parameter legality check used at elaboration.
package adder_pkg;

  // Controller states: waiting, stepping through slices, result-valid pulse.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // A configuration is usable when the word splits into whole digits and
  // the word is at least two bits wide (signed overflow needs a sign bit
  // plus one more).
  function automatic bit cfg_legal(int width, int digit);
    return (width >= 2) && (digit >= 1) && (digit <= width) &&
           ((width % digit) == 0);
  endfunction

  // Number of slices processed per operation.
  function automatic int ndig_of(int width, int digit);
    return width / digit;
  endfunction

endpackage

// File: rtl/serial_adder_n_if.sv
// Operation request / result bundle for the digit-serial adder.
//
// Handshake: the requester raises start for one or more cycles with
// A, B, sub and Cin stable. The adder takes the request on a rising edge
// only while it is not busy (idle, or in the single cycle where done is
// high); a request seen while busy is dropped, not queued. busy stays high
// for the whole computation and done pulses for exactly one cycle when S,
// Cout and ovf have been refreshed. Results hold until the next done.
interface serial_adder_n_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] S;
  logic             Cout;
  logic             ovf;

  // Requester side.
  modport master (
    output start, sub, A, B, Cin,
    input  busy, done, S, Cout, ovf
  );

  // Adder side.
  modport slave (
    input  start, sub, A, B, Cin,
    output busy, done, S, Cout, ovf
  );
endinterface

// File: rtl/add_slice.sv
// DIGIT-bit ripple-carry adder built from full-adder cells. Also reports the
// carry into its top bit so the caller can derive signed overflow.
module add_slice #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [DIGIT:0] c;

  // Ripple the carry through one full-adder cell per bit.
  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < DIGIT; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout  = c[DIGIT];
  assign c_msb = c[DIGIT - 1];

endmodule

// File: rtl/serial_adder_n.sv
// Digit-serial add/subtract unit. Operands are latched on request, then one
// DIGIT-bit slice is added per cycle (LSB slice first) through a single
// shared add_slice, with the carry kept in a register between slices.
// Subtraction is A + ~B + 1. The controller state is visible on dbg_state.
module serial_adder_n
  import adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  serial_adder_n_if.slave   bus,
  output state_t            dbg_state
);

  localparam int NDIG  = ndig_of(WIDTH, DIGIT);
  localparam int CNT_W = $clog2(NDIG + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NDIG - 1);
  localparam logic [CNT_W-1:0] IDX_ONE  = CNT_W'(1);

  // Reject unusable WIDTH/DIGIT combinations at elaboration.
  if (!cfg_legal(WIDTH, DIGIT)) begin : g_cfg_check
    $error("serial_adder_n: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry_q;
  logic [CNT_W-1:0] idx_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] s_q;
  logic             cout_q;
  logic             ovf_q;

  logic [DIGIT-1:0] slice_sum;
  logic             slice_cout;
  logic             slice_c_msb;
  logic [WIDTH-1:0] a_shift;
  logic [WIDTH-1:0] b_shift;
  logic [WIDTH-1:0] acc_next;

  // The operand registers always present the slice under work at bit 0.
  add_slice #(
    .DIGIT (DIGIT)
  ) u_slice (
    .a     (a_q[DIGIT-1:0]),
    .b     (b_q[DIGIT-1:0]),
    .cin   (carry_q),
    .sum   (slice_sum),
    .cout  (slice_cout),
    .c_msb (slice_c_msb)
  );

  if (NDIG > 1) begin : g_multi
    // Finished slices, newest at the top; after the last slice the first
    // (LSB) slice has been shifted down to bit 0.
    logic [WIDTH-DIGIT-1:0] acc_q;

    // Shift each new slice result into the partial-result register.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        acc_q <= '0;
      end else if (state == RUN) begin
        acc_q <= acc_next[WIDTH-1:DIGIT];
      end
    end

    assign acc_next = {slice_sum, acc_q};
    assign a_shift  = {{DIGIT{1'b0}}, a_q[WIDTH-1:DIGIT]};
    assign b_shift  = {{DIGIT{1'b0}}, b_q[WIDTH-1:DIGIT]};
  end else begin : g_single
    // One slice covers the whole word; nothing to collect or shift.
    assign acc_next = slice_sum;
    assign a_shift  = '0;
    assign b_shift  = '0;
  end

  // Controller plus operand/carry/result registers; outputs are registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            a_q     <= bus.A;
            b_q     <= bus.sub ? ~bus.B : bus.B;
            carry_q <= bus.sub | bus.Cin;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state   <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          a_q     <= a_shift;
          b_q     <= b_shift;
          carry_q <= slice_cout;
          if (idx_q == LAST_IDX) begin
            idx_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            s_q    <= acc_next;
            cout_q <= slice_cout;
            ovf_q  <= slice_c_msb ^ slice_cout;
            state  <= DONE;
          end else begin
            idx_q <= idx_q + IDX_ONE;
          end
        end
        default: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.S     = s_q;
  assign bus.Cout  = cout_q;
  assign bus.ovf   = ovf_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_serial_adder_n.sv
// Bench for serial_adder_n: three instances (8/1, 16/4, 8/8) share one set
// of drivers. A cycle-level reference model computes each result with
// plain integer arithmetic and predicts busy/done timing from a countdown.
module tb_serial_adder_n;
  import adder_pkg::*;

  localparam int NDUT = 3;

  // Clock / reset block.
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start;
  logic        sub;
  logic        cin;
  logic [15:0] a_in;
  logic [15:0] b_in;

  serial_adder_n_if #(.WIDTH(8))  if0 ();
  serial_adder_n_if #(.WIDTH(16)) if1 ();
  serial_adder_n_if #(.WIDTH(8))  if2 ();

  assign if0.start = start;
  assign if0.sub   = sub;
  assign if0.Cin   = cin;
  assign if0.A     = a_in[7:0];
  assign if0.B     = b_in[7:0];
  assign if1.start = start;
  assign if1.sub   = sub;
  assign if1.Cin   = cin;
  assign if1.A     = a_in;
  assign if1.B     = b_in;
  assign if2.start = start;
  assign if2.sub   = sub;
  assign if2.Cin   = cin;
  assign if2.A     = a_in[7:0];
  assign if2.B     = b_in[7:0];

  state_t dbg0, dbg1, dbg2;

  serial_adder_n #(.WIDTH(8),  .DIGIT(1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0), .dbg_state(dbg0));
  serial_adder_n #(.WIDTH(16), .DIGIT(4)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1), .dbg_state(dbg1));
  serial_adder_n #(.WIDTH(8),  .DIGIT(8)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2), .dbg_state(dbg2));

  int cfg_w [NDUT] = '{8, 16, 8};
  int cfg_n [NDUT] = '{8, 4, 1};

  // Reference model state.
  int          m_rem  [NDUT];
  logic        m_done [NDUT];
  logic [15:0] m_s    [NDUT];
  logic        m_cout [NDUT];
  logic        m_ovf  [NDUT];
  logic [15:0] p_s    [NDUT];
  logic        p_cout [NDUT];
  logic        p_ovf  [NDUT];

  int total = 0;
  int bad   = 0;

  // Scoreboard compare.
  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d actual=%0h expected=%0h t=%0t", nm, i, act, exp, $time);
    end
  endtask

  function automatic logic dut_busy(int i);
    case (i)
      0:       return if0.busy;
      1:       return if1.busy;
      default: return if2.busy;
    endcase
  endfunction

  function automatic logic dut_done(int i);
    case (i)
      0:       return if0.done;
      1:       return if1.done;
      default: return if2.done;
    endcase
  endfunction

  function automatic logic [15:0] dut_s(int i);
    case (i)
      0:       return {8'h00, if0.S};
      1:       return if1.S;
      default: return {8'h00, if2.S};
    endcase
  endfunction

  function automatic logic dut_cout(int i);
    case (i)
      0:       return if0.Cout;
      1:       return if1.Cout;
      default: return if2.Cout;
    endcase
  endfunction

  function automatic logic dut_ovf(int i);
    case (i)
      0:       return if0.ovf;
      1:       return if1.ovf;
      default: return if2.ovf;
    endcase
  endfunction

  // Whole-word result straight from the arithmetic definition.
  task automatic calc(input int w, input logic [15:0] a, input logic [15:0] b,
                      input logic s, input logic c,
                      output logic [15:0] rs, output logic rc, output logic ro);
    logic [31:0] mask, aa, bb, tot;
    mask = (32'd1 << w) - 32'd1;
    aa   = {16'd0, a} & mask;
    bb   = (s ? ~{16'd0, b} : {16'd0, b}) & mask;
    tot  = aa + bb + (s ? 32'd1 : {31'd0, c});
    rs   = tot[15:0] & mask[15:0];
    rc   = tot[w];
    ro   = (aa[w-1] == bb[w-1]) && (tot[w-1] != aa[w-1]);
  endtask

  // Advance the model by one rising edge using the inputs in force.
  task automatic model_step();
    for (int i = 0; i < NDUT; i++) begin
      m_done[i] = 1'b0;
      if (!rst_n) begin
        m_rem[i]  = 0;
        m_s[i]    = '0;
        m_cout[i] = 1'b0;
        m_ovf[i]  = 1'b0;
      end else if (m_rem[i] > 0) begin
        m_rem[i]--;
        if (m_rem[i] == 0) begin
          m_done[i] = 1'b1;
          m_s[i]    = p_s[i];
          m_cout[i] = p_cout[i];
          m_ovf[i]  = p_ovf[i];
        end
      end else if (start) begin
        calc(cfg_w[i], a_in, b_in, sub, cin, p_s[i], p_cout[i], p_ovf[i]);
        m_rem[i] = cfg_n[i];
      end
    end
  endtask

  // One clock: model at the rising edge, compare all outputs at the falling edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    for (int i = 0; i < NDUT; i++) begin
      chk("busy", i, 32'(dut_busy(i)), 32'(m_rem[i] > 0));
      chk("done", i, 32'(dut_done(i)), 32'(m_done[i]));
      chk("S",    i, {16'd0, dut_s(i)}, {16'd0, m_s[i]});
      chk("Cout", i, 32'(dut_cout(i)), 32'(m_cout[i]));
      chk("ovf",  i, 32'(dut_ovf(i)),  32'(m_ovf[i]));
    end
  endtask

  // Driver tasks.
  task automatic launch(input logic [15:0] a, input logic [15:0] b, input logic s, input logic c);
    a_in  = a;
    b_in  = b;
    sub   = s;
    cin   = c;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int which, output int n, output int bcnt);
    n    = 0;
    bcnt = 0;
    while (!dut_done(which) && n < 40) begin
      tick();
      n++;
      if (dut_busy(which)) bcnt++;
    end
    if (!dut_done(which)) begin
      total++;
      bad++;
      $display("FAIL done_timeout dut%0d actual=no_done expected=done", which);
    end
  endtask

  // Latency counts the accepting edge as cycle 1.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic s, input logic c,
                        input int which, output int lat, output int bcnt);
    int n, bc, b0;
    launch(a, b, s, c);
    b0 = int'(dut_busy(which));
    wait_done(which, n, bc);
    lat  = 1 + n;
    bcnt = b0 + bc;
  endtask

  task automatic settle();
    start = 1'b0;
    repeat (10) tick();
  endtask

  initial begin
    int lat, bc, n, dn;
    for (int i = 0; i < NDUT; i++) begin
      m_rem[i] = 0; m_done[i] = 0; m_s[i] = 0; m_cout[i] = 0; m_ovf[i] = 0;
      p_s[i] = 0; p_cout[i] = 0; p_ovf[i] = 0;
    end
    // Reset with start held high: start must be ignored.
    rst_n = 1'b0; start = 1'b1; sub = 1'b0; cin = 1'b0;
    a_in  = 16'hFFFF; b_in = 16'hFFFF;
    repeat (3) tick();
    chk("rst_state", 0, 32'(dbg0), 32'(IDLE));
    chk("rst_state", 1, 32'(dbg1), 32'(IDLE));
    chk("rst_state", 2, 32'(dbg2), 32'(IDLE));
    chk("rst_S", 0, {16'd0, dut_s(0)}, 32'h0);
    start = 1'b0;
    rst_n = 1'b1;
    repeat (2) tick();

    // 0F + 01 on the bit-serial instance.
    run_op(16'h000F, 16'h0001, 1'b0, 1'b0, 0, lat, bc);
    chk("lat_add", 0, 32'(lat), 32'd9);
    chk("busy_cnt", 0, 32'(bc), 32'd8);
    chk("S_0F_01", 0, {16'd0, dut_s(0)}, 32'h10);
    chk("C_0F_01", 0, 32'(dut_cout(0)), 32'd0);
    // Back-to-back request in the done cycle.
    run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 0, lat, bc);
    chk("lat_b2b", 0, 32'(lat), 32'd9);
    chk("S_FF_01", 0, {16'd0, dut_s(0)}, 32'h00);
    chk("C_FF_01", 0, 32'(dut_cout(0)), 32'd1);
    chk("V_FF_01", 0, 32'(dut_ovf(0)), 32'd0);
    settle();

    run_op(16'h007F, 16'h0001, 1'b0, 1'b0, 0, lat, bc);
    chk("S_7F_01", 0, {16'd0, dut_s(0)}, 32'h80);
    chk("V_7F_01", 0, 32'(dut_ovf(0)), 32'd1);
    settle();

    run_op(16'h0005, 16'h0007, 1'b1, 1'b1, 0, lat, bc);
    chk("S_05m07", 0, {16'd0, dut_s(0)}, 32'hFE);
    chk("C_05m07", 0, 32'(dut_cout(0)), 32'd0);
    chk("V_05m07", 0, 32'(dut_ovf(0)), 32'd0);
    settle();

    run_op(16'h0080, 16'h0001, 1'b1, 1'b0, 0, lat, bc);
    chk("S_80m01", 0, {16'd0, dut_s(0)}, 32'h7F);
    chk("V_80m01", 0, 32'(dut_ovf(0)), 32'd1);
    chk("C_80m01", 0, 32'(dut_cout(0)), 32'd1);
    settle();

    // New request mid-computation must be dropped.
    launch(16'h000F, 16'h0001, 1'b0, 1'b0);
    tick(); tick();
    launch(16'h0033, 16'h0044, 1'b1, 1'b0);
    wait_done(0, n, bc);
    chk("mid_lat", 0, 32'(4 + n), 32'd9);
    chk("mid_S", 0, {16'd0, dut_s(0)}, 32'h10);
    settle();

    // One-cycle reset in the fourth busy cycle aborts the operation.
    launch(16'h0021, 16'h0012, 1'b0, 1'b0);
    tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("abort_busy", 0, 32'(dut_busy(0)), 32'd0);
    chk("abort_S", 0, {16'd0, dut_s(0)}, 32'h0);
    chk("abort_done", 0, 32'(dut_done(0)), 32'd0);
    dn = 0;
    repeat (12) begin
      tick();
      if (dut_done(0)) dn++;
    end
    chk("abort_no_done", 0, 32'(dn), 32'd0);
    run_op(16'h0021, 16'h0012, 1'b0, 1'b0, 0, lat, bc);
    chk("after_rst_lat", 0, 32'(lat), 32'd9);
    chk("after_rst_S", 0, {16'd0, dut_s(0)}, 32'h33);
    settle();

    // 16-bit word, 4-bit digits.
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1, lat, bc);
    chk("lat_16x4", 1, 32'(lat), 32'd5);
    chk("busy_16x4", 1, 32'(bc), 32'd4);
    chk("S_16x4", 1, {16'd0, dut_s(1)}, 32'h0000);
    chk("C_16x4", 1, 32'(dut_cout(1)), 32'd1);
    settle();

    // Single-slice configuration.
    run_op(16'h0003, 16'h0004, 1'b0, 1'b1, 2, lat, bc);
    chk("lat_8x8", 2, 32'(lat), 32'd2);
    chk("busy_8x8", 2, 32'(bc), 32'd1);
    chk("S_8x8", 2, {16'd0, dut_s(2)}, 32'h08);
    settle();

    // Randomized traffic including sporadic resets.
    repeat (600) begin
      start = ($urandom_range(0, 2) == 0);
      sub   = 1'($urandom_range(0, 1));
      cin   = 1'($urandom_range(0, 1));
      a_in  = 16'($urandom);
      b_in  = 16'($urandom);
      rst_n = ($urandom_range(0, 60) != 0);
      tick();
    end
    rst_n = 1'b1;
    settle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_adder_n.md
SERIAL_ADDER_N -- requirements
Module: serial_adder_n

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand/result width in bits, WIDTH >= 2.
REQ-002 SHALL have parameter DIGIT, default 1: bits processed per cycle, 1 <= DIGIT <= WIDTH, WIDTH % DIGIT == 0.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-005 SHALL have port start, input, 1 bit: request a new operation.
REQ-006 SHALL have port sub, input, 1 bit: 0 = add, 1 = subtract (A - B).
REQ-007 SHALL have port A, input, WIDTH bits: operand A.
REQ-008 SHALL have port B, input, WIDTH bits: operand B.
REQ-009 SHALL have port Cin, input, 1 bit: carry-in, used in add mode only.
REQ-010 SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse marking result valid.
REQ-012 SHALL have port S, output, WIDTH bits: sum/difference.
REQ-013 SHALL have port Cout, output, 1 bit: final carry (add) / not-borrow (sub).
REQ-014 SHALL have port ovf, output, 1 bit: two's-complement signed overflow.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DONE; NDIG = WIDTH/DIGIT.
REQ-016 In IDLE or DONE, start=1 at edge k SHALL latch A, B, sub, Cin into internal registers and enter RUN.
REQ-017 Operand latch SHALL store B inverted and set the initial carry to 1 when sub=1; Cin is ignored when sub=1.
REQ-018 RUN SHALL last exactly NDIG cycles; each cycle adds one DIGIT-bit slice, LSB slice first, and carries through a registered carry bit.
REQ-019 busy SHALL be high exactly in cycles k+1 .. k+NDIG.
REQ-020 After the last RUN cycle the FSM SHALL enter DONE; done SHALL be high for exactly one cycle (k+NDIG+1). In the following cycle the FSM SHALL return to IDLE, unless start is accepted.
REQ-021 S, Cout and ovf SHALL update only on the transition into DONE, and SHALL hold until the next transition into DONE or reset.
REQ-022 ovf SHALL equal the carry into the MSB XOR the carry out of the MSB for the final slice.
REQ-023 start in RUN SHALL be ignored; operands SHALL NOT be re-latched.
REQ-024 start asserted in the DONE cycle SHALL be accepted (back-to-back operation), giving a RUN start one cycle after done.
REQ-025 Wrap-around: result SHALL be modulo 2^WIDTH; the carry-out of the final slice is reported only in Cout.
REQ-026 DIGIT == WIDTH SHALL yield NDIG = 1, with busy high for one cycle.

Reset
REQ-027 rst_n=0 at a rising edge SHALL force IDLE and set busy=0, done=0, S=0, Cout=0 and ovf=0, and SHALL clear the operand and carry registers.
REQ-028 Reset during RUN SHALL abort the operation with no done pulse; the first start after release SHALL behave per REQ-016.
REQ-029 start SHALL be ignored in any cycle where rst_n=0.

Structure
REQ-030 State encoding (IDLE/RUN/DONE enum) and a WIDTH/DIGIT legality check function SHALL reside in shared package adder_pkg.
REQ-031 A sub-module add_slice (DIGIT-bit combinational ripple of full-adder cells) SHALL be instantiated once and reused each RUN cycle.
REQ-032 Slice selection SHALL use a shift register or slice counter of width ceil(log2(NDIG+1)); no WIDTH-bit adder SHALL be inferred.

Verification
REQ-033 WIDTH=8, DIGIT=1, add, A=8'h0F, B=8'h01, Cin=0 -> S=8'h10, Cout=0, ovf=0; done pulses 9 cycles after the start edge.
REQ-034 Add, A=8'hFF, B=8'h01, Cin=0 -> S=8'h00, Cout=1, ovf=0; add, A=8'h7F, B=8'h01 -> S=8'h80, ovf=1.
REQ-035 Sub, A=8'h05, B=8'h07, Cin=1 -> S=8'hFE, Cout=0, ovf=0 (Cin ignored); sub, A=8'h80, B=8'h01 -> S=8'h7F, ovf=1.
REQ-036 start pulsed with new operands mid-RUN -> result reflects the original operands; start in the DONE cycle -> second done exactly NDIG+1 cycles later.
REQ-037 rst_n=0 for one cycle at RUN cycle 4 -> busy=0 and S=0 next cycle, with no done pulse; a subsequent start completes normally.
REQ-038 WIDTH=16, DIGIT=4, A=16'hFFFF, B=16'h0001 -> S=16'h0000, Cout=1; busy high 4 cycles, done at start+5.
